// File: rtl/md_issue_ctrl_if.sv
// Control/status bundle between the issue controller and the multiply/divide unit.
interface md_issue_ctrl_if;
    logic [2:0] MDControl_EX;
    logic       Start_EX;
    logic       MD_EX_NE;
    logic       MTMD_RE;
    logic       md_busy;

    modport master (
        output MDControl_EX,
        output Start_EX,
        output MD_EX_NE,
        output MTMD_RE,
        input  md_busy
    );

    modport slave (
        input  MDControl_EX,
        input  Start_EX,
        input  MD_EX_NE,
        input  MTMD_RE,
        output md_busy
    );
endinterface

// File: rtl/md_issue_ctrl.sv
// EX-stage issue/hazard controller for the multiply/divide unit.
// Define MD_STALL_CNT_EN to build the stall_cycles counter; otherwise it reads as zero.
//
// state   | meaning
// --------+----------------------------------------------------------
// ST_IDLE | unit free; a mult/div in EX may issue
// ST_MULT | mult/multu in flight, cnt counts remaining occupied cycles
// ST_DIV  | div/divu in flight, cnt counts remaining occupied cycles
module md_issue_ctrl #(
    parameter int MULT_LAT = 4,
    parameter int DIV_LAT  = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [31:0]            instr_id,
    input  logic [31:0]            instr_ex,
    input  logic                   valid_ex,
    input  logic                   exc_flush,
    md_issue_ctrl_if.master        md,
    output logic                   stall_id,
    output logic                   md_err,
    output logic [31:0]            stall_cycles
);

    typedef enum logic [2:0] {
        CLS_NONE  = 3'd0,
        CLS_MULT  = 3'd1,
        CLS_MULTU = 3'd2,
        CLS_DIV   = 3'd3,
        CLS_DIVU  = 3'd4,
        CLS_MTHI  = 3'd5,
        CLS_MTLO  = 3'd6,
        CLS_MF    = 3'd7
    } md_class_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MULT = 2'd1,
        ST_DIV  = 2'd2
    } md_state_t;

    localparam logic [3:0] MULT_CNT = 4'(MULT_LAT - 1);
    localparam logic [3:0] DIV_CNT  = 4'(DIV_LAT - 1);

    // Only opcode and funct matter; the argument is {opcode, funct}.
    function automatic md_class_t decode(input logic [11:0] op_funct);
        md_class_t c;
        c = CLS_NONE;
        if (op_funct[11:6] == 6'b000000) begin
            case (op_funct[5:0])
                6'h18:        c = CLS_MULT;
                6'h19:        c = CLS_MULTU;
                6'h1A:        c = CLS_DIV;
                6'h1B:        c = CLS_DIVU;
                6'h11:        c = CLS_MTHI;
                6'h13:        c = CLS_MTLO;
                6'h10, 6'h12: c = CLS_MF;
                default:      c = CLS_NONE;
            endcase
        end
        return c;
    endfunction

    md_class_t cls_id;
    md_class_t cls_ex;
    md_state_t state;
    logic [3:0] cnt;
    logic       mt_mem;
    logic       occ_q;
    logic       ex_md;
    logic       ex_muldiv;
    logic       ex_mt;
    logic       ex_is_div;
    logic       id_hilo;
    logic       issue;
    logic       accept;
    logic       busy_fsm;
    logic       unused_fields;

    assign unused_fields = ^{instr_id[25:6], instr_ex[25:6]};

    assign cls_id = decode({instr_id[31:26], instr_id[5:0]});
    assign cls_ex = decode({instr_ex[31:26], instr_ex[5:0]});

    assign ex_md     = valid_ex && (cls_ex != CLS_NONE) && (cls_ex != CLS_MF);
    assign ex_muldiv = ex_md && (cls_ex inside {CLS_MULT, CLS_MULTU, CLS_DIV, CLS_DIVU});
    assign ex_mt     = ex_md && (cls_ex inside {CLS_MTHI, CLS_MTLO});
    assign ex_is_div = (cls_ex == CLS_DIV) || (cls_ex == CLS_DIVU);
    assign id_hilo   = (cls_id != CLS_NONE);

    assign md.MDControl_EX = ex_md ? 3'(cls_ex) : 3'd0;
    assign md.Start_EX     = ex_muldiv;
    assign md.MD_EX_NE     = exc_flush | ~valid_ex;
    assign md.MTMD_RE      = exc_flush & mt_mem;

    assign issue    = md.Start_EX & ~md.MD_EX_NE;
    assign busy_fsm = (state != ST_IDLE);
    assign accept   = issue & ~busy_fsm;

    assign stall_id = id_hilo & (busy_fsm | issue);

    // occ_q is what md_busy should read one edge later: the unit raises Busy
    // on the edge after issue and drops it LAT edges later.
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= ST_IDLE;
            cnt    <= 4'd0;
            mt_mem <= 1'b0;
            occ_q  <= 1'b0;
            md_err <= 1'b0;
        end else begin
            mt_mem <= ex_mt & ~md.MD_EX_NE;
            occ_q  <= busy_fsm | accept;
            if ((occ_q != md.md_busy) || (issue && busy_fsm)) begin
                md_err <= 1'b1;
            end
            case (state)
                ST_IDLE: begin
                    if (issue) begin
                        state <= ex_is_div ? ST_DIV : ST_MULT;
                        cnt   <= ex_is_div ? DIV_CNT : MULT_CNT;
                    end
                end
                default: begin
                    // exc_flush deliberately has no effect here: the unit keeps computing.
                    if (cnt <= 4'd1) begin
                        state <= ST_IDLE;
                        cnt   <= 4'd0;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
            endcase
        end
    end

`ifdef MD_STALL_CNT_EN
    logic [31:0] stall_cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_q <= 32'h0;
        end else if (stall_id) begin
            stall_cnt_q <= stall_cnt_q + 32'h1;
        end
    end

    assign stall_cycles = stall_cnt_q;
`else
    assign stall_cycles = 32'h0;
`endif

endmodule

// File: tb/tb_md_issue_ctrl.sv
// Self-checking bench for md_issue_ctrl: directed scenarios then randomized traffic
// against a cycle-window reference model of unit occupancy.
module tb_md_issue_ctrl;
    localparam int MULT_LAT = 4;
    localparam int DIV_LAT  = 8;
`ifdef MD_STALL_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    localparam logic [5:0] F_MULT  = 6'h18;
    localparam logic [5:0] F_MULTU = 6'h19;
    localparam logic [5:0] F_DIV   = 6'h1A;
    localparam logic [5:0] F_DIVU  = 6'h1B;
    localparam logic [5:0] F_MTHI  = 6'h11;
    localparam logic [5:0] F_MTLO  = 6'h13;
    localparam logic [5:0] F_MFHI  = 6'h10;
    localparam logic [5:0] F_MFLO  = 6'h12;
    localparam logic [5:0] F_ADD   = 6'h20;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] instr_id;
    logic [31:0] instr_ex;
    logic        valid_ex;
    logic        exc_flush;
    logic        stall_id;
    logic        md_err;
    logic [31:0] stall_cycles;

    md_issue_ctrl_if md_bus();

    md_issue_ctrl #(.MULT_LAT(MULT_LAT), .DIV_LAT(DIV_LAT)) dut (
        .clk          (clk),
        .reset        (reset),
        .instr_id     (instr_id),
        .instr_ex     (instr_ex),
        .valid_ex     (valid_ex),
        .exc_flush    (exc_flush),
        .md           (md_bus),
        .stall_id     (stall_id),
        .md_err       (md_err),
        .stall_cycles (stall_cycles)
    );

    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_fail = 0;

    // Model: the unit is Busy on cycles [bs, be]; ID must stall on [bs, be-1] and on the issue cycle.
    int          t     = 0;
    int          bs    = 0;
    int          be    = -1;
    bit          mt_m  = 1'b0;
    bit          err_m = 1'b0;
    logic [31:0] cnt_m = 32'h0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, t);
        end
    endtask

    // 1-4 mult/multu/div/divu, 5 mthi, 6 mtlo, 7 mfhi/mflo, 0 anything else
    function automatic int cls(input logic [31:0] ins);
        if (ins[31:26] != 6'd0) return 0;
        case (ins[5:0])
            F_MULT:         return 1;
            F_MULTU:        return 2;
            F_DIV:          return 3;
            F_DIVU:         return 4;
            F_MTHI:         return 5;
            F_MTLO:         return 6;
            F_MFHI, F_MFLO: return 7;
            default:        return 0;
        endcase
    endfunction

    function automatic logic [31:0] rt(input logic [5:0] f);
        logic [19:0] mid;
        mid = 20'($urandom);
        return {6'b000000, mid, f};
    endfunction

    function automatic logic [31:0] rand_ins();
        logic [5:0] fl [8];
        int         k;
        fl[0] = F_MULT; fl[1] = F_MULTU; fl[2] = F_DIV;  fl[3] = F_DIVU;
        fl[4] = F_MTHI; fl[5] = F_MTLO;  fl[6] = F_MFHI; fl[7] = F_MFLO;
        k = $urandom_range(0, 9);
        if (k < 8) return rt(fl[k]);
        if (k == 8) return rt(F_ADD);
        return {6'h23, 26'($urandom)};
    endfunction

    task automatic step(input logic [31:0] id, input logic [31:0] ex, input bit v, input bit f,
                        input bit flip);
        int         c_id;
        int         c_ex;
        bit         occ;
        bit         busy_m;
        bit         start_m;
        bit         ne_m;
        bit         issue_m;
        bit         stall_m;
        logic [2:0] code_m;
        c_id    = cls(id);
        c_ex    = cls(ex);
        occ     = (t >= bs) && (t < be);
        busy_m  = (t >= bs) && (t <= be);
        code_m  = (v && c_ex >= 1 && c_ex <= 6) ? 3'(c_ex) : 3'd0;
        start_m = v && c_ex >= 1 && c_ex <= 4;
        ne_m    = f || !v;
        issue_m = start_m && !ne_m;
        stall_m = (c_id != 0) && (occ || issue_m);
        instr_id  = id;
        instr_ex  = ex;
        valid_ex  = v;
        exc_flush = f;
        md_bus.md_busy = busy_m ^ flip;
        @(negedge clk);
        chk("mdcontrol", 32'(md_bus.MDControl_EX), 32'(code_m));
        chk("start",     32'(md_bus.Start_EX), 32'(start_m));
        chk("md_ex_ne",  32'(md_bus.MD_EX_NE), 32'(ne_m));
        chk("mtmd_re",   32'(md_bus.MTMD_RE), 32'(f && mt_m));
        chk("stall_id",  32'(stall_id), 32'(stall_m));
        chk("md_err",    32'(md_err), 32'(err_m));
        chk("stall_cyc", stall_cycles, cnt_m);
        @(posedge clk);
        #1;
        if (flip) err_m = 1'b1;
        if (issue_m) begin
            if (occ) begin
                err_m = 1'b1;
            end else begin
                bs = t + 1;
                be = t + ((c_ex <= 2) ? MULT_LAT : DIV_LAT);
            end
        end
        mt_m = !ne_m && (c_ex == 5 || c_ex == 6);
        if (CNT_EN && stall_m) cnt_m = cnt_m + 32'h1;
        t++;
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        instr_id  = rand_ins();
        instr_ex  = rand_ins();
        valid_ex  = 1'($urandom);
        exc_flush = 1'b0;
        md_bus.md_busy = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        bs    = 0;
        be    = -1;
        mt_m  = 1'b0;
        err_m = 1'b0;
        cnt_m = 32'h0;
        t++;
    endtask

    task automatic bubble(input logic [31:0] id);
        step(id, rt(F_ADD), 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        logic [31:0] nop;
        logic [31:0] ex;
        bit          v;
        bit          f;
        nop   = 32'h0000_0020;
        reset = 1'b1;
        do_reset();
        do_reset();

        // mult + mflo, then divu + mfhi: 4 + 8 stall cycles
        step(rt(F_MFLO), rt(F_MULT), 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) bubble(rt(F_MFLO));
        step(rt(F_MFHI), rt(F_DIVU), 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) bubble(rt(F_MFHI));
        chk("stall_total", stall_cycles, CNT_EN ? 32'd12 : 32'd0);

        // mthi then flush next cycle -> restore; mthi flushed in EX -> no restore
        step(nop, rt(F_MTHI), 1'b1, 1'b0, 1'b0);
        step(nop, nop, 1'b1, 1'b1, 1'b0);
        step(nop, nop, 1'b1, 1'b0, 1'b0);
        step(nop, rt(F_MTLO), 1'b1, 1'b0, 1'b0);
        step(nop, rt(F_MTHI), 1'b1, 1'b1, 1'b0);
        step(nop, nop, 1'b1, 1'b1, 1'b0);

        // div flushed in its issue cycle never occupies the unit
        step(rt(F_MFLO), rt(F_DIV), 1'b1, 1'b1, 1'b0);
        bubble(rt(F_MFLO));
        bubble(rt(F_MTLO));

        // back-to-back multu right as the FSM returns to idle, flush mid-flight is ignored
        step(rt(F_MULTU), rt(F_MULTU), 1'b1, 1'b0, 1'b0);
        step(rt(F_MULTU), nop, 1'b1, 1'b1, 1'b0);
        bubble(rt(F_MULTU));
        bubble(rt(F_MULTU));
        step(rt(F_MFHI), rt(F_MULTU), 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) bubble(rt(F_MFHI));

        // reset while div has cnt=3
        step(rt(F_MFHI), rt(F_DIV), 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) bubble(rt(F_MFHI));
        do_reset();
        bubble(rt(F_MFHI));
        bubble(rt(F_MTHI));

        // illegal issue while busy sets sticky md_err
        step(nop, rt(F_MULT), 1'b1, 1'b0, 1'b0);
        step(nop, rt(F_DIV), 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) bubble(nop);
        do_reset();

        // md_busy disagreeing with the mirror sets sticky md_err
        bubble(nop);
        step(nop, nop, 1'b1, 1'b0, 1'b1);
        bubble(nop);
        bubble(nop);
        do_reset();

        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 59) == 0) begin
                do_reset();
            end else begin
                ex = rand_ins();
                v  = ($urandom_range(0, 9) < 8);
                f  = ($urandom_range(0, 9) == 0);
                if ((t >= bs) && (t < be) && (cls(ex) >= 1) && (cls(ex) <= 4)) ex = rt(F_MFLO);
                step(rand_ins(), ex, v, f, 1'b0);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
